// File: rtl/pzhsbus_payload_downsizer_if.sv
// Valid/ready/payload bundle for one side of the pzhsbus downsizer.
// WIDTH sets the payload width; the producer uses the master modport.
interface pzhsbus_payload_downsizer_if #(
   parameter int WIDTH = 64
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] payload;

   modport master (output valid, output payload, input ready);
   modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/pzhsbus_payload_downsizer.sv
// Splits each wide pzhsbus payload into NUM_BEATS narrow beats, accepting the
// next wide word on the same cycle the previous word's last beat is taken.
module pzhsbus_payload_downsizer #(
   parameter int  WIDE_WIDTH   = 256,
   parameter int  NARROW_WIDTH = 64,
   parameter bit  MSB_FIRST    = 1'b0,
   localparam int NUM_BEATS    = (NARROW_WIDTH > 0) ? (WIDE_WIDTH / NARROW_WIDTH) : 1,
   localparam int IDX_W        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_clear,
   pzhsbus_payload_downsizer_if.slave         slave_if,
   pzhsbus_payload_downsizer_if.master        master_if,
   output logic                               o_last,
   output logic [IDX_W-1:0]                   o_beat_index
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

   if ((NARROW_WIDTH < 1) ||
       ((WIDE_WIDTH % ((NARROW_WIDTH < 1) ? 1 : NARROW_WIDTH)) != 0)) begin : g_bad_cfg
      $error("pzhsbus_payload_downsizer: WIDE_WIDTH must be a nonzero multiple of NARROW_WIDTH");
   end

   // Beat 0 is the lowest slice unless MSB_FIRST reverses the order.
   function automatic logic [NARROW_WIDTH-1:0] slice_beat(
      input logic [WIDE_WIDTH-1:0] word,
      input logic [IDX_W-1:0]      cnt
   );
      int sel;
      sel = MSB_FIRST ? (int'(LAST_IDX) - int'(cnt)) : int'(cnt);
      return word[sel*NARROW_WIDTH +: NARROW_WIDTH];
   endfunction

   logic                  held_valid_q, held_valid_d;
   logic [WIDE_WIDTH-1:0] held_data_q,  held_data_d;
   logic [IDX_W-1:0]      beat_cnt_q,   beat_cnt_d;

   logic last_beat;
   logic beat_take;
   logic slave_ready;
   logic slave_take;

   assign last_beat   = held_valid_q && (beat_cnt_q == LAST_IDX);
   assign beat_take   = held_valid_q && master_if.ready;
   // Ready is combinational from the consumer's ready so words chain without a bubble.
   assign slave_ready = !i_clear && (!held_valid_q || (master_if.ready && last_beat));
   assign slave_take  = slave_if.valid && slave_ready;

   assign slave_if.ready    = slave_ready;
   assign master_if.valid   = held_valid_q;
   assign master_if.payload = slice_beat(held_data_q, beat_cnt_q);
   assign o_last            = last_beat;
   assign o_beat_index      = beat_cnt_q;

   always_comb begin
      held_valid_d = held_valid_q;
      held_data_d  = held_data_q;
      beat_cnt_d   = beat_cnt_q;
      if (i_clear) begin
         held_valid_d = 1'b0;
         beat_cnt_d   = '0;
      end else begin
         if (beat_take) begin
            if (last_beat) begin
               held_valid_d = 1'b0;
               beat_cnt_d   = '0;
            end else begin
               beat_cnt_d = beat_cnt_q + IDX_W'(1);
            end
         end
         // A new word can only arrive when the holder is empty or draining its last beat.
         if (slave_take) begin
            held_valid_d = 1'b1;
            held_data_d  = slave_if.payload;
            beat_cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         held_valid_q <= 1'b0;
         held_data_q  <= '0;
         beat_cnt_q   <= '0;
      end else begin
         held_valid_q <= held_valid_d;
         held_data_q  <= held_data_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_pzhsbus_payload_downsizer.sv
// Directed bench for pzhsbus_payload_downsizer: LSB-first 256->64, MSB-first
// 256->64 and a 64->64 register-slice configuration.
module tb_pzhsbus_payload_downsizer;

   logic clk;
   logic rst;
   logic clr;
   int   checks;
   int   failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pzhsbus_payload_downsizer_if #(.WIDTH(256)) s0 ();
   pzhsbus_payload_downsizer_if #(.WIDTH(64))  m0 ();
   pzhsbus_payload_downsizer_if #(.WIDTH(256)) s1 ();
   pzhsbus_payload_downsizer_if #(.WIDTH(64))  m1 ();
   pzhsbus_payload_downsizer_if #(.WIDTH(64))  s2 ();
   pzhsbus_payload_downsizer_if #(.WIDTH(64))  m2 ();

   logic       last0, last1, last2;
   logic [1:0] idx0, idx1;
   logic [0:0] idx2;

   pzhsbus_payload_downsizer #(.WIDE_WIDTH(256), .NARROW_WIDTH(64), .MSB_FIRST(1'b0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_clear(clr), .slave_if(s0), .master_if(m0),
      .o_last(last0), .o_beat_index(idx0));

   pzhsbus_payload_downsizer #(.WIDE_WIDTH(256), .NARROW_WIDTH(64), .MSB_FIRST(1'b1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_clear(clr), .slave_if(s1), .master_if(m1),
      .o_last(last1), .o_beat_index(idx1));

   pzhsbus_payload_downsizer #(.WIDE_WIDTH(64), .NARROW_WIDTH(64), .MSB_FIRST(1'b0)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_clear(clr), .slave_if(s2), .master_if(m2),
      .o_last(last2), .o_beat_index(idx2));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slice k of the word holds the byte (base+k) repeated eight times.
   function automatic logic [63:0] beat(input logic [7:0] base, input int k);
      logic [7:0] b;
      b = base + 8'(k);
      return {8{b}};
   endfunction

   function automatic logic [255:0] mkword(input logic [7:0] base);
      logic [255:0] w;
      for (int k = 0; k < 4; k++) w[k*64 +: 64] = beat(base, k);
      return w;
   endfunction

   initial begin
      logic [255:0] w_a;
      logic [63:0]  e;
      logic [7:0]   base;
      int           k;

      checks   = 0;
      failures = 0;
      rst = 1'b1;
      clr = 1'b0;
      s0.valid = 1'b0; s0.payload = '0; m0.ready = 1'b0;
      s1.valid = 1'b0; s1.payload = '0; m1.ready = 1'b0;
      s2.valid = 1'b0; s2.payload = '0; m2.ready = 1'b0;
      w_a = 256'h3333333333333333_2222222222222222_1111111111111111_0000000000000000;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_m_valid", m0.valid, 0);
      chk("rst_last", last0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_s_ready", s0.ready, 1);
      chk("rel_m_valid", m0.valid, 0);
      chk("rel_payload", m0.payload, 0);
      chk("rel_last", last0, 0);
      chk("rel_idx", idx0, 0);
      chk("rel_s1_ready", s1.ready, 1);
      chk("rel_s2_ready", s2.ready, 1);

      // Single word, LSB slice first
      @(negedge clk);
      s0.valid = 1'b1; s0.payload = w_a; m0.ready = 1'b1;
      #1;
      chk("t2_accept_ready", s0.ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s0.valid = 1'b0;
         #1;
         e = {16{4'(i)}};
         chk("t2_valid", m0.valid, 1);
         chk("t2_payload", m0.payload, e);
         chk("t2_last", last0, (i == 3));
         chk("t2_idx", idx0, i);
         chk("t2_s_ready", s0.ready, (i == 3));
      end
      @(negedge clk);
      #1;
      chk("t2_idle_valid", m0.valid, 0);

      // Back-to-back words A then B, both sides always ready
      s0.valid = 1'b1; s0.payload = mkword(8'hA0); m0.ready = 1'b1;
      #1;
      chk("t3_accept_a", s0.ready, 1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) s0.payload = mkword(8'hB0);
         if (c == 5) s0.valid = 1'b0;
         #1;
         base = (c <= 4) ? 8'hA0 : 8'hB0;
         chk("t3_valid", m0.valid, 1);
         chk("t3_payload", m0.payload, beat(base, (c - 1) % 4));
         chk("t3_last", last0, ((c % 4) == 0));
         chk("t3_s_ready", s0.ready, ((c == 4) || (c == 8)));
      end
      @(negedge clk);
      #1;
      chk("t3_idle_valid", m0.valid, 0);

      // Backpressure: consumer ready 1,0,0,1,0,0,...
      s0.valid = 1'b1; s0.payload = mkword(8'hC0); m0.ready = 1'b0;
      #1;
      chk("t4_accept", s0.ready, 1);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         s0.valid = (i == 0) ? 1'b0 : 1'b1;
         s0.payload = mkword(8'hF0);
         m0.ready = ((i % 3) == 0);
         #1;
         chk("t4_valid", m0.valid, 1);
         chk("t4_payload", m0.payload, beat(8'hC0, k));
         chk("t4_idx", idx0, k);
         chk("t4_s_ready", s0.ready, ((i % 3) == 0) && (k == 3));
         if ((i % 3) == 0) k++;
      end
      @(negedge clk);
      s0.valid = 1'b0;
      #1;
      chk("t4_next_word", m0.payload, beat(8'hF0, 0));
      chk("t4_next_idx", idx0, 0);
      m0.ready = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      #1;
      chk("t4_drained", m0.valid, 0);

      // Clear after two of four beats
      s0.valid = 1'b1; s0.payload = mkword(8'hD0); m0.ready = 1'b1;
      #1;
      chk("t5_accept", s0.ready, 1);
      @(negedge clk);
      s0.valid = 1'b0;
      #1;
      chk("t5_beat0", m0.payload, beat(8'hD0, 0));
      @(negedge clk);
      #1;
      chk("t5_beat1", m0.payload, beat(8'hD0, 1));
      @(negedge clk);
      clr = 1'b1; s0.valid = 1'b1; s0.payload = mkword(8'hE0);
      #1;
      chk("t5_clr_s_ready", s0.ready, 0);
      chk("t5_clr_valid", m0.valid, 1);
      chk("t5_clr_idx", idx0, 2);
      @(negedge clk);
      clr = 1'b0; s0.valid = 1'b0;
      #1;
      chk("t5_post_valid", m0.valid, 0);
      chk("t5_post_s_ready", s0.ready, 1);
      chk("t5_post_idx", idx0, 0);
      @(negedge clk);
      s0.valid = 1'b1;
      #1;
      chk("t5_e_accept", s0.ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s0.valid = 1'b0;
         #1;
         chk("t5_e_payload", m0.payload, beat(8'hE0, i));
         chk("t5_e_idx", idx0, i);
      end
      @(negedge clk);
      #1;
      chk("t5_e_idle", m0.valid, 0);

      // Reset asserted mid-word discards the remaining beats
      s0.valid = 1'b1; s0.payload = mkword(8'h70); m0.ready = 1'b1;
      @(negedge clk);
      s0.valid = 1'b0;
      #1;
      chk("rmid_beat0", m0.payload, beat(8'h70, 0));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rmid_valid", m0.valid, 0);
      chk("rmid_payload", m0.payload, 0);
      chk("rmid_idx", idx0, 0);
      chk("rmid_last", last0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rmid_s_ready", s0.ready, 1);
      chk("rmid_rel_valid", m0.valid, 0);
      m0.ready = 1'b0;

      // MSB-first slice order
      s1.valid = 1'b1; s1.payload = mkword(8'h50); m1.ready = 1'b1;
      #1;
      chk("t6a_accept", s1.ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s1.valid = 1'b0;
         #1;
         chk("t6a_payload", m1.payload, beat(8'h50, 3 - i));
         chk("t6a_idx", idx1, i);
         chk("t6a_last", last1, (i == 3));
      end
      @(negedge clk);
      #1;
      chk("t6a_idle", m1.valid, 0);

      // Single-beat register slice
      s2.valid = 1'b1; s2.payload = 64'h1122334455667788; m2.ready = 1'b1;
      #1;
      chk("t6b_accept", s2.ready, 1);
      @(negedge clk);
      s2.payload = 64'h99AABBCCDDEEFF00;
      #1;
      chk("t6b_x_payload", m2.payload, 64'h1122334455667788);
      chk("t6b_x_last", last2, 1);
      chk("t6b_x_idx", idx2, 0);
      chk("t6b_x_s_ready", s2.ready, 1);
      @(negedge clk);
      s2.valid = 1'b0;
      #1;
      chk("t6b_y_payload", m2.payload, 64'h99AABBCCDDEEFF00);
      chk("t6b_y_last", last2, 1);
      @(negedge clk);
      #1;
      chk("t6b_idle_valid", m2.valid, 0);
      chk("t6b_idle_last", last2, 0);
      s2.valid = 1'b1; s2.payload = 64'hDEADBEEFCAFEF00D; m2.ready = 1'b0;
      @(negedge clk);
      s2.valid = 1'b0;
      #1;
      chk("t6b_bp_valid", m2.valid, 1);
      chk("t6b_bp_s_ready", s2.ready, 0);
      @(negedge clk);
      #1;
      chk("t6b_bp_hold", m2.payload, 64'hDEADBEEFCAFEF00D);
      m2.ready = 1'b1;
      #1;
      chk("t6b_bp_release", s2.ready, 1);
      @(negedge clk);
      #1;
      chk("t6b_bp_idle", m2.valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
